btn_event_unit: RTL and testbench

//  Front-end for the board push-buttons. Synchronises, debounces and decodes N raw

---
 rtl/btn_event_unit_pkg.sv | 19 +
 rtl/btn_event_unit_chan.sv | 100 ++++++++++
 rtl/btn_event_unit.sv | 44 ++++
 tb/tb_btn_event_unit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/btn_event_unit_pkg.sv
// Shared types and helpers for the push-button event front-end.
package btn_event_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } rep_state_e;

    // Counter width able to hold values up to n-1 with one bit of headroom.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_event_unit_chan.sv
// One button channel: polarity fix, 2-FF sync, debounce, edge pulses and
// auto-repeat state machine.
module btn_event_unit_chan
    import btn_event_unit_pkg::*;
#(
    parameter bit          ACTIVE_LOW    = 1'b0,
    parameter int unsigned DEB_CYCLES    = 500000,
    parameter bit          REPEAT_EN     = 1'b1,
    parameter int unsigned REPEAT_DELAY  = 25000000,
    parameter int unsigned REPEAT_PERIOD = 5000000
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic press,
    output logic rel,
    output logic rep
);

    localparam int unsigned DEB_W = cnt_width(DEB_CYCLES);
    localparam int unsigned REP_W = cnt_width(max_u(REPEAT_DELAY, REPEAT_PERIOD));

    logic             p_norm;
    logic             sync1;
    logic             sync2;
    logic [DEB_W-1:0] deb_cnt;
    logic [REP_W-1:0] rep_cnt;
    rep_state_e       state;
    logic             accept_c;

    assign p_norm   = pin ^ ACTIVE_LOW;
    assign accept_c = (sync2 != level) && (deb_cnt == DEB_W'(DEB_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            deb_cnt <= '0;
            level   <= 1'b0;
            press   <= 1'b0;
            rel     <= 1'b0;
            rep     <= 1'b0;
            rep_cnt <= '0;
            state   <= ST_IDLE;
        end else begin
            sync1 <= p_norm;
            sync2 <= sync1;
            press <= 1'b0;
            rel   <= 1'b0;
            rep   <= 1'b0;

            // Debounce: count cycles the synced pin disagrees with the accepted level.
            if (sync2 == level) begin
                deb_cnt <= '0;
            end else if (accept_c) begin
                deb_cnt <= '0;
                level   <= ~level;
                press   <= ~level;
                rel     <= level;
            end else begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end

            // Auto-repeat; an accepted edge always restarts it and suppresses any tick.
            if (accept_c) begin
                rep_cnt <= '0;
                state   <= (!level && REPEAT_EN) ? ST_HOLD : ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        rep_cnt <= '0;
                    end
                    ST_HOLD: begin
                        if (rep_cnt == REP_W'(REPEAT_DELAY - 1)) begin
                            rep_cnt <= '0;
                            rep     <= 1'b1;
                            state   <= ST_REPEAT;
                        end else begin
                            rep_cnt <= rep_cnt + REP_W'(1);
                        end
                    end
                    ST_REPEAT: begin
                        if (rep_cnt == REP_W'(REPEAT_PERIOD - 1)) begin
                            rep_cnt <= '0;
                            rep     <= 1'b1;
                        end else begin
                            rep_cnt <= rep_cnt + REP_W'(1);
                        end
                    end
                    default: begin
                        rep_cnt <= '0;
                        state   <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/btn_event_unit.sv
// Push-button front-end: N independent debounce/event channels plus a
// combined press-or-repeat step strobe.
module btn_event_unit
    import btn_event_unit_pkg::*;
#(
    parameter int unsigned N_BTN         = 8,
    parameter bit          ACTIVE_LOW    = 1'b0,
    parameter int unsigned DEB_CYCLES    = 500000,
    parameter bit          REPEAT_EN     = 1'b1,
    parameter int unsigned REPEAT_DELAY  = 25000000,
    parameter int unsigned REPEAT_PERIOD = 5000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_repeat,
    output logic [N_BTN-1:0] btn_evt
);

    for (genvar i = 0; i < int'(N_BTN); i++) begin : gen_chan
        btn_event_unit_chan #(
            .ACTIVE_LOW    (ACTIVE_LOW),
            .DEB_CYCLES    (DEB_CYCLES),
            .REPEAT_EN     (REPEAT_EN),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
        ) u_chan (
            .clk   (clk),
            .rst   (rst),
            .pin   (btn[i]),
            .level (btn_level[i]),
            .press (btn_press[i]),
            .rel   (btn_release[i]),
            .rep   (btn_repeat[i])
        );
    end

    // Both sources are flop outputs and never coincide on a channel.
    assign btn_evt = btn_press | btn_repeat;

endmodule

// File: tb/tb_btn_event_unit.sv
// Scoreboard bench for btn_event_unit: two instances (active-high and
// active-low pins), expected pulses queued by stimulus, checked by a monitor.
module tb_btn_event_unit;

    localparam int unsigned N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, rst_al;
    logic [N-1:0] btn, btn_al;
    logic [N-1:0] lvl0, prs0, rel0, rep0, evt0;
    logic [N-1:0] lvl1, prs1, rel1, rep1, evt1;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    btn_event_unit #(
        .N_BTN(N), .ACTIVE_LOW(1'b0), .DEB_CYCLES(4), .REPEAT_EN(1'b1),
        .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
    ) dut (
        .clk(clk), .rst(rst), .btn(btn),
        .btn_level(lvl0), .btn_press(prs0), .btn_release(rel0),
        .btn_repeat(rep0), .btn_evt(evt0)
    );

    btn_event_unit #(
        .N_BTN(N), .ACTIVE_LOW(1'b1), .DEB_CYCLES(4), .REPEAT_EN(1'b1),
        .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
    ) dut_al (
        .clk(clk), .rst(rst_al), .btn(btn_al),
        .btn_level(lvl1), .btn_press(prs1), .btn_release(rel1),
        .btn_repeat(rep1), .btn_evt(evt1)
    );

    typedef struct {
        int         cyc;
        int         dut;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] rep;
        logic [3:0] lvl;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic push(input int c, input int d, input logic [3:0] p,
                        input logic [3:0] r, input logic [3:0] rp, input logic [3:0] l);
        exp_t x;
        x.cyc = c; x.dut = d; x.press = p; x.rel = r; x.rep = rp; x.lvl = l;
        q.push_back(x);
    endtask

    task automatic mon(input int d, input logic [3:0] l, input logic [3:0] p,
                       input logic [3:0] r, input logic [3:0] rp, input logic [3:0] e);
        exp_t x;
        if ((p | r | rp) == 4'b0000) return;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse dut%0d cyc=%0d press=%b rel=%b rep=%b", d, cyc, p, r, rp);
            return;
        end
        x = q.pop_front();
        if (x.cyc != cyc || x.dut != d || x.press != p || x.rel != r || x.rep != rp ||
            x.lvl != l || e != (x.press | x.rep)) begin
            errors++;
            $display("FAIL event got dut%0d cyc=%0d p=%b r=%b rp=%b lvl=%b evt=%b exp dut%0d cyc=%0d p=%b r=%b rp=%b lvl=%b evt=%b",
                     d, cyc, p, r, rp, l, e, x.dut, x.cyc, x.press, x.rel, x.rep, x.lvl, x.press | x.rep);
        end
    endtask

    always @(negedge clk) begin
        mon(0, lvl0, prs0, rel0, rep0, evt0);
        mon(1, lvl1, prs1, rel1, rep1, evt1);
    end

    task automatic chk_zero(input int d, input string name);
        logic [19:0] got;
        got = (d == 0) ? {lvl0, prs0, rel0, rep0, evt0} : {lvl1, prs1, rel1, rep1, evt1};
        checks++;
        if (got !== 20'h0) begin
            errors++;
            $display("FAIL %s dut%0d outputs=%h required 0", name, d, got);
        end
    endtask

    task automatic chk_lvl(input string name, input logic [3:0] got, input logic [3:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s level=%b required %b", name, got, req);
        end
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    int t, r, r2;

    initial begin
        rst    = 1'b1;
        rst_al = 1'b1;
        btn    = 4'($urandom);
        btn_al = 4'($urandom);

        // Reset for two edges with random pins.
        @(negedge clk); chk_zero(0, "rst_cycle1"); chk_zero(1, "rst_cycle1");
        btn    = 4'($urandom);
        btn_al = 4'($urandom);
        @(negedge clk); chk_zero(0, "rst_cycle2"); chk_zero(1, "rst_cycle2");
        rst = 1'b0;
        btn = 4'b0000;
        @(negedge clk); chk_zero(0, "first_after_rst");
        repeat (5) after_edge();

        // Press on channel 0, released before the first repeat tick.
        after_edge(); t = cyc;
        btn[0] = 1'b1;
        push(t + 6, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        repeat (8) after_edge();
        btn[0] = 1'b0;
        push(t + 14, 0, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
        repeat (10) after_edge();

        // Glitch of DEB_CYCLES-1 cycles on channel 1.
        after_edge();
        btn[1] = 1'b1;
        repeat (3) after_edge();
        btn[1] = 1'b0;
        repeat (12) after_edge();
        chk_lvl("glitch_level", lvl0, 4'b0000);

        // Long hold on channel 2 with auto-repeat, then release.
        after_edge(); t = cyc;
        btn[2] = 1'b1;
        push(t + 6, 0, 4'b0100, 4'b0000, 4'b0000, 4'b0100);
        for (int k = 0; k < 9; k++)
            push(t + 16 + 3 * k, 0, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
        repeat (36) after_edge();
        btn[2] = 1'b0;
        push(t + 42, 0, 4'b0000, 4'b0100, 4'b0000, 4'b0000);
        repeat (12) after_edge();

        // Simultaneous press on channels 0 and 3.
        after_edge(); t = cyc;
        btn = 4'b1001;
        push(t + 6, 0, 4'b1001, 4'b0000, 4'b0000, 4'b1001);
        repeat (7) after_edge();
        btn = 4'b0000;
        push(t + 13, 0, 4'b0000, 4'b1001, 4'b0000, 4'b0000);
        repeat (10) after_edge();

        // Active-low instance: channel 0 held low through reset.
        btn_al = 4'b1110;
        repeat (3) after_edge();
        r = cyc;
        rst_al = 1'b0;
        push(r + 6, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        push(r + 16, 1, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
        push(r + 19, 1, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
        push(r + 22, 1, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
        repeat (23) after_edge();
        rst_al = 1'b1;
        after_edge(); @(negedge clk); chk_zero(1, "mid_repeat_rst1");
        after_edge(); @(negedge clk); chk_zero(1, "mid_repeat_rst2");
        r2 = cyc;
        rst_al = 1'b0;
        push(r2 + 6, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        push(r2 + 16, 1, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
        push(r2 + 19, 1, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
        push(r2 + 22, 1, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
        repeat (17) after_edge();
        btn_al = 4'b1111;
        push(r2 + 23, 1, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
        repeat (12) after_edge();

        @(negedge clk);
        chk_lvl("final_level_dut0", lvl0, 4'b0000);
        chk_lvl("final_level_dut1", lvl1, 4'b0000);
        while (q.size() != 0) begin
            exp_t x;
            x = q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_event dut%0d cyc=%0d p=%b r=%b rp=%b never seen",
                     x.dut, x.cyc, x.press, x.rel, x.rep);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
